// File: rtl/multicycle_control_pkg.sv
// Shared opcode, func, ALU-op and sequencer-state encodings for the 16-bit CPU.
// Imported by multicycle_control, mc_alu_decode and the ALU.
package multicycle_control_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [3:0] BNE_OP = 4'd0;
    localparam logic [3:0] BEQ_OP = 4'd1;
    localparam logic [3:0] BGZ_OP = 4'd2;
    localparam logic [3:0] BLZ_OP = 4'd3;
    localparam logic [3:0] ADI_OP = 4'd4;
    localparam logic [3:0] ORI_OP = 4'd5;
    localparam logic [3:0] LHI_OP = 4'd6;
    localparam logic [3:0] LWD_OP = 4'd7;
    localparam logic [3:0] SWD_OP = 4'd8;
    localparam logic [3:0] JMP_OP = 4'd9;
    localparam logic [3:0] ALU_OP = 4'd15;

    localparam logic [5:0] FUNC_ADD = 6'd0;
    localparam logic [5:0] FUNC_SUB = 6'd1;
    localparam logic [5:0] FUNC_AND = 6'd2;
    localparam logic [5:0] FUNC_ORR = 6'd3;
    localparam logic [5:0] FUNC_NOT = 6'd4;
    localparam logic [5:0] FUNC_TCP = 6'd5;
    localparam logic [5:0] FUNC_SHL = 6'd6;
    localparam logic [5:0] FUNC_SHR = 6'd7;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h5,
        ALU_ORR = 4'h6,
        ALU_NOT = 4'h9,
        ALU_SHR = 4'hA,
        ALU_TCP = 4'hC,
        ALU_SHL = 4'hD,
        ALU_LHI = 4'hF
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } mc_state_e;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRC_B_RT   = 2'd0;
    localparam logic [1:0] SRC_B_ONE  = 2'd1;
    localparam logic [1:0] SRC_B_SEXT = 2'd2;
    localparam logic [1:0] SRC_B_ZEXT = 2'd3;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == BNE_OP) || (op == BEQ_OP);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == LWD_OP) || (op == SWD_OP);
    endfunction

    // BEQ branches on a taken compare, BNE on a not-taken one.
    function automatic logic branch_sense(input logic [3:0] op, input logic taken);
        return (op == BEQ_OP) ? taken : ~taken;
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational opcode/func to ALU-op map used in EX; also flags whether the
// instruction is one the sequencer knows how to execute.
module mc_alu_decode
    import multicycle_control_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output logic       known
);

    // Map the instruction fields to the EX-stage ALU operation.
    always_comb begin
        alu_op = ALU_ADD;
        known  = 1'b0;
        case (opcode)
            ALU_OP: begin
                case (func)
                    FUNC_ADD: begin alu_op = ALU_ADD; known = 1'b1; end
                    FUNC_SUB: begin alu_op = ALU_SUB; known = 1'b1; end
                    FUNC_AND: begin alu_op = ALU_AND; known = 1'b1; end
                    FUNC_ORR: begin alu_op = ALU_ORR; known = 1'b1; end
                    FUNC_NOT: begin alu_op = ALU_NOT; known = 1'b1; end
                    FUNC_TCP: begin alu_op = ALU_TCP; known = 1'b1; end
                    FUNC_SHL: begin alu_op = ALU_SHL; known = 1'b1; end
                    FUNC_SHR: begin alu_op = ALU_SHR; known = 1'b1; end
                    default:  begin alu_op = ALU_ADD; known = 1'b0; end
                endcase
            end
            ADI_OP, LWD_OP, SWD_OP, JMP_OP: begin
                alu_op = ALU_ADD;
                known  = 1'b1;
            end
            ORI_OP: begin
                alu_op = ALU_ORR;
                known  = 1'b1;
            end
            LHI_OP: begin
                alu_op = ALU_LHI;
                known  = 1'b1;
            end
            BNE_OP, BEQ_OP: begin
                alu_op = ALU_SUB;
                known  = 1'b1;
            end
            default: begin
                alu_op = ALU_ADD;
                known  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer driving the datapath and the shared memory port.
// Optional retired-instruction counter enabled by `define MC_INST_COUNT_EN.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  opcode,
    input  logic [5:0]  func,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        inst_done,
    output logic [15:0] num_inst
);

    mc_state_e  state_r;
    logic [3:0] ex_alu_op_s;
    logic       inst_known_s;
    logic       take_branch_s;

    mc_alu_decode u_alu_decode (
        .opcode (opcode),
        .func   (func),
        .alu_op (ex_alu_op_s),
        .known  (inst_known_s)
    );

    assign take_branch_s = branch_sense(opcode, branch_taken);

    // Sequencer state register and next-state selection.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IF;
        end else begin
            case (state_r)
                ST_IF: begin
                    if (mem_ready) state_r <= ST_ID;
                    else           state_r <= ST_IF;
                end
                ST_ID: begin
                    if ((opcode == JMP_OP) || !inst_known_s) state_r <= ST_IF;
                    else                                     state_r <= ST_EX;
                end
                ST_EX: begin
                    if (is_branch(opcode))      state_r <= ST_IF;
                    else if (is_mem_op(opcode)) state_r <= ST_MEM;
                    else                        state_r <= ST_WB;
                end
                ST_MEM: begin
                    if (!mem_ready)              state_r <= ST_MEM;
                    else if (opcode == SWD_OP)   state_r <= ST_IF;
                    else                         state_r <= ST_WB;
                end
                ST_WB:   state_r <= ST_IF;
                default: state_r <= ST_IF;
            endcase
        end
    end

    // Control decode; reset forces every strobe low in the same cycle.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RT;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        inst_done  = 1'b0;
        if (reset) begin
            inst_done = 1'b0;
        end else begin
            case (state_r)
                ST_IF: begin
                    mem_read  = 1'b1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    alu_src_b = SRC_B_ONE;
                    alu_op    = ALU_ADD;
                end
                ST_ID: begin
                    // Branch target is precomputed into ALUOut for every opcode.
                    alu_src_b = SRC_B_SEXT;
                    alu_op    = ALU_ADD;
                    if (opcode == JMP_OP) begin
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_JUMP;
                        inst_done = 1'b1;
                    end else if (!inst_known_s) begin
                        inst_done = 1'b1;
                    end else begin
                        inst_done = 1'b0;
                    end
                end
                ST_EX: begin
                    alu_src_a = 1'b1;
                    alu_op    = ex_alu_op_s;
                    case (opcode)
                        ALU_OP:         alu_src_b = SRC_B_RT;
                        ORI_OP, LHI_OP: alu_src_b = SRC_B_ZEXT;
                        BNE_OP, BEQ_OP: begin
                            alu_src_b = SRC_B_RT;
                            inst_done = 1'b1;
                            if (take_branch_s) begin
                                pc_write = 1'b1;
                                pc_src   = PC_SRC_ALUOUT;
                            end else begin
                                pc_write = 1'b0;
                            end
                        end
                        default:        alu_src_b = SRC_B_SEXT;
                    endcase
                end
                ST_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (opcode == LWD_OP);
                    mem_write = (opcode == SWD_OP);
                    inst_done = mem_ready && (opcode == SWD_OP);
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (opcode == ALU_OP);
                    mem_to_reg = (opcode == LWD_OP);
                    inst_done  = 1'b1;
                end
                default: begin
                    inst_done = 1'b0;
                end
            endcase
        end
    end

`ifdef MC_INST_COUNT_EN
    logic [WORD_SIZE-1:0] num_inst_r;

    // Retired-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_inst_r <= 16'h0000;
        end else if (inst_done) begin
            num_inst_r <= num_inst_r + 16'h0001;
        end else begin
            num_inst_r <= num_inst_r;
        end
    end

    assign num_inst = num_inst_r;
`else
    assign num_inst = 16'h0000;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised self-checking bench for multicycle_control against an
// instruction-level reference model of the stage sequence.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  opcode = 4'd0;
    logic [5:0]  func = 6'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic        reg_write, reg_dst, mem_to_reg, inst_done;
    logic [15:0] num_inst;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .inst_done(inst_done), .num_inst(num_inst)
    );

    localparam logic [3:0] OP_BNE = 4'd0, OP_BEQ = 4'd1, OP_ADI = 4'd4, OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6, OP_LWD = 4'd7, OP_SWD = 4'd8, OP_JMP = 4'd9;
    localparam logic [3:0] OP_ALU = 4'd15;
    localparam int PH_IF = 0, PH_ID = 1, PH_EX = 2, PH_MEM = 3, PH_WB = 4;
    localparam logic [17:0] ALL = 18'h3FFFF;

    // Vector layout: rd wr iod irw pcw pcs[2] asa asb[2] aop[4] rw rdst m2r done
    logic [17:0] obs;
    assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, inst_done};

    int n_tests = 0;
    int n_fail = 0;
    logic [15:0] cnt_model = 16'd0;
    logic [17:0] obs_q[$], exp_q[$], msk_q[$];
    logic [15:0] cnto_q[$], cnte_q[$];

    function automatic logic [15:0] cnt_exp();
`ifdef MC_INST_COUNT_EN
        return cnt_model;
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic known(input logic [3:0] op, input logic [5:0] fn);
        if (op == OP_ALU) return fn < 6'd8;
        return op inside {OP_BNE, OP_BEQ, OP_ADI, OP_ORI, OP_LHI, OP_LWD, OP_SWD, OP_JMP};
    endfunction

    function automatic logic [3:0] alu_of_func(input logic [5:0] fn);
        case (fn)
            6'd0: return 4'h0;  6'd1: return 4'h1;  6'd2: return 4'h5;  6'd3: return 4'h6;
            6'd4: return 4'h9;  6'd5: return 4'hC;  6'd6: return 4'hD;  default: return 4'hA;
        endcase
    endfunction

    // Expected control outputs for one cycle of a given stage.
    function automatic logic [17:0] exp_vec(input int ph, input logic [3:0] op,
                                            input logic [5:0] fn, input logic br, input logic rdy);
        logic mr = 1'b0, mw = 1'b0, iod = 1'b0, irw = 1'b0, pcw = 1'b0, asa = 1'b0;
        logic rw = 1'b0, rd = 1'b0, m2r = 1'b0, dn = 1'b0;
        logic [1:0] pcs = 2'd0, asb = 2'd0;
        logic [3:0] aop = 4'h0;
        case (ph)
            PH_IF: begin mr = 1'b1; irw = rdy; pcw = rdy; asb = 2'd1; end
            PH_ID: begin
                asb = 2'd2;
                if (op == OP_JMP) begin pcw = 1'b1; pcs = 2'd2; dn = 1'b1; end
                else if (!known(op, fn)) dn = 1'b1;
            end
            PH_EX: begin
                asa = 1'b1;
                if (op == OP_ALU) begin asb = 2'd0; aop = alu_of_func(fn); end
                else if (op == OP_ORI) begin asb = 2'd3; aop = 4'h6; end
                else if (op == OP_LHI) begin asb = 2'd3; aop = 4'hF; end
                else if (op == OP_BNE || op == OP_BEQ) begin
                    asb = 2'd0; aop = 4'h1; dn = 1'b1;
                    if ((op == OP_BEQ) == br) begin pcw = 1'b1; pcs = 2'd1; end
                end else asb = 2'd2;
            end
            PH_MEM: begin
                iod = 1'b1; mr = (op == OP_LWD); mw = (op == OP_SWD);
                dn = rdy && (op == OP_SWD);
            end
            default: begin rw = 1'b1; rd = (op == OP_ALU); m2r = (op == OP_LWD); dn = 1'b1; end
        endcase
        return {mr, mw, iod, irw, pcw, pcs, asa, asb, aop, rw, rd, m2r, dn};
    endfunction

    // Drive one instruction through its stage list (optionally cut short) and record samples.
    task automatic drive_inst(input logic [3:0] op, input logic [5:0] fn, input logic br,
                              input int if_stall, input int mem_stall, input int abort_len);
        int ph_q[$];
        logic rdy_q[$];
        logic [17:0] e;
        for (int i = 0; i < if_stall; i++) begin ph_q.push_back(PH_IF); rdy_q.push_back(1'b0); end
        ph_q.push_back(PH_IF); rdy_q.push_back(1'b1);
        ph_q.push_back(PH_ID); rdy_q.push_back(1'($urandom_range(0, 1)));
        if (op != OP_JMP && known(op, fn)) begin
            ph_q.push_back(PH_EX); rdy_q.push_back(1'($urandom_range(0, 1)));
            if (op == OP_LWD || op == OP_SWD) begin
                for (int i = 0; i < mem_stall; i++) begin ph_q.push_back(PH_MEM); rdy_q.push_back(1'b0); end
                ph_q.push_back(PH_MEM); rdy_q.push_back(1'b1);
                if (op == OP_LWD) begin ph_q.push_back(PH_WB); rdy_q.push_back(1'($urandom_range(0, 1))); end
            end else if (op != OP_BNE && op != OP_BEQ) begin
                ph_q.push_back(PH_WB); rdy_q.push_back(1'($urandom_range(0, 1)));
            end
        end
        if (abort_len > 0) while (ph_q.size() > abort_len) begin void'(ph_q.pop_back()); void'(rdy_q.pop_back()); end
        foreach (ph_q[i]) begin
            @(negedge clk);
            reset = 1'b0; opcode = op; func = fn; branch_taken = br; mem_ready = rdy_q[i];
            #1;
            e = exp_vec(ph_q[i], op, fn, br, rdy_q[i]);
            obs_q.push_back(obs);
            exp_q.push_back(e);
            msk_q.push_back((ph_q[i] == PH_EX && op != OP_ALU) ? (ALL & ~18'h00400) : ALL);
            cnto_q.push_back(num_inst);
            cnte_q.push_back(cnt_exp());
            if (e[0]) cnt_model = cnt_model + 16'd1;
        end
    endtask

    task automatic clear_q();
        obs_q.delete(); exp_q.delete(); msk_q.delete(); cnto_q.delete(); cnte_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = OP_ALU; func = 6'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_tests++;
            if (obs !== 18'h0) begin n_fail++; $display("FAIL reset_outputs cyc%0d: got %h want 0", i, obs); end
            n_tests++;
            if (num_inst !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", num_inst); end
        end
        cnt_model = 16'd0;
    endtask

    task automatic test_add();
        clear_q();
        drive_inst(OP_ALU, 6'd0, 1'b0, 0, 0, 0);
        foreach (obs_q[i]) begin
            n_tests++;
            if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                n_fail++; $display("FAIL add cyc%0d: got %h want %h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
            end
            n_tests++;
            if (obs_q[i][3:2] !== ((i == 3) ? 2'b11 : 2'b00)) begin
                n_fail++; $display("FAIL add_regwr cyc%0d: got %b", i, obs_q[i][3:2]);
            end
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        n_tests++;
        if (num_inst !== cnt_exp()) begin n_fail++; $display("FAIL add_count: got %h want %h", num_inst, cnt_exp()); end
        n_tests++;
        if (obs[17] !== 1'b1) begin n_fail++; $display("FAIL add_next_if: mem_read got %b want 1", obs[17]); end
    endtask

    task automatic test_lwd_stall();
        int held = 0;
        clear_q();
        drive_inst(OP_LWD, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 0, 3, 0);
        n_tests++;
        if (obs_q.size() != 8) begin n_fail++; $display("FAIL lwd_len: got %0d want 8", obs_q.size()); end
        foreach (obs_q[i]) begin
            n_tests++;
            if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                n_fail++; $display("FAIL lwd cyc%0d: got %h want %h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
            end
            if (i >= 3 && obs_q[i][17] && obs_q[i][15]) held++;
            n_tests++;
            if (cnto_q[i] !== cnte_q[i]) begin n_fail++; $display("FAIL lwd_count cyc%0d: got %h want %h", i, cnto_q[i], cnte_q[i]); end
        end
        n_tests++;
        if (held != 4) begin n_fail++; $display("FAIL lwd_mem_hold: got %0d want 4", held); end
        n_tests++;
        if (obs_q[7][1] !== 1'b1) begin n_fail++; $display("FAIL lwd_mem_to_reg: got %b want 1", obs_q[7][1]); end
    endtask

    task automatic test_branches();
        logic [3:0] ops [4] = '{OP_BEQ, OP_BNE, OP_BEQ, OP_BNE};
        logic brs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic want_pcw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            clear_q();
            drive_inst(ops[k], 6'($urandom_range(0, 63)), brs[k], 0, 0, 0);
            n_tests++;
            if (obs_q.size() != 3) begin n_fail++; $display("FAIL branch%0d_len: got %0d want 3", k, obs_q.size()); end
            n_tests++;
            if (obs_q[2][13:11] !== (want_pcw[k] ? 3'b101 : 3'b000)) begin
                n_fail++; $display("FAIL branch%0d_pc: got %b want pcw=%b pcs=01", k, obs_q[2][13:11], want_pcw[k]);
            end
            foreach (obs_q[i]) begin
                n_tests++;
                if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                    n_fail++; $display("FAIL branch%0d cyc%0d: got %h want %h", k, i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
                end
            end
        end
    endtask

    task automatic test_jmp();
        clear_q();
        drive_inst(OP_JMP, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1, 0, 0);
        foreach (obs_q[i]) begin
            n_tests++;
            if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                n_fail++; $display("FAIL jmp cyc%0d: got %h want %h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
            end
        end
        n_tests++;
        if (obs_q[2][13:11] !== 3'b110) begin n_fail++; $display("FAIL jmp_pc: got %b want 110", obs_q[2][13:11]); end
        @(negedge clk); mem_ready = 1'b0; #1;
        n_tests++;
        if (obs !== exp_vec(PH_IF, OP_JMP, 6'd0, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL jmp_next_if: got %h want %h", obs, exp_vec(PH_IF, OP_JMP, 6'd0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_mid_swd();
        logic seen_rw = 1'b0;
        clear_q();
        drive_inst(OP_SWD, 6'd0, 1'b0, 0, 3, 5);
        foreach (obs_q[i]) begin
            n_tests++;
            if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                n_fail++; $display("FAIL swd_abort cyc%0d: got %h want %h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
            end
            seen_rw = seen_rw | obs_q[i][3];
        end
        @(negedge clk); reset = 1'b1; mem_ready = 1'b0; #1;
        seen_rw = seen_rw | reg_write;
        n_tests++;
        if (obs !== 18'h0) begin n_fail++; $display("FAIL swd_reset_cycle: got %h want 0 (mem_write=%b)", obs, mem_write); end
        cnt_model = 16'd0;
        @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
        n_tests++;
        if (obs !== exp_vec(PH_IF, OP_SWD, 6'd0, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL swd_after_reset: got %h want %h", obs, exp_vec(PH_IF, OP_SWD, 6'd0, 1'b0, 1'b0));
        end
        n_tests++;
        if (num_inst !== 16'h0) begin n_fail++; $display("FAIL swd_count: got %h want 0", num_inst); end
        n_tests++;
        if (seen_rw !== 1'b0) begin n_fail++; $display("FAIL swd_reg_write: got 1 want 0"); end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [5:0] fn;
        for (int n = 0; n < 150; n++) begin
            clear_q();
            op = 4'($urandom_range(0, 15));
            fn = ($urandom_range(0, 9) < 7) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            drive_inst(op, fn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
            foreach (obs_q[i]) begin
                n_tests++;
                if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                    n_fail++; $display("FAIL rand op=%h fn=%h cyc%0d: got %h want %h", op, fn, i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
                end
                n_tests++;
                if (cnto_q[i] !== cnte_q[i]) begin
                    n_fail++; $display("FAIL rand_count cyc%0d: got %h want %h", i, cnto_q[i], cnte_q[i]);
                end
            end
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        n_tests++;
        if (num_inst !== cnt_exp()) begin n_fail++; $display("FAIL rand_final_count: got %h want %h", num_inst, cnt_exp()); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lwd_stall();
        test_branches();
        test_jmp();
        test_reset_mid_swd();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
